// File: rtl/circle_hit_pkg.sv
// Purpose: shared constants and elaboration-time helpers for the circle hit-test pipeline.
// Contents: pipeline latency, centre-x / product-width helpers, squared-radius thresholds.
package circle_hit_pkg;

    localparam int unsigned LAT        = 3;
    localparam int unsigned DEF_R      = 60;
    localparam int unsigned DEF_RING_W = 0;

    // x centre of circle i
    function automatic int unsigned centre_x(input int unsigned x0, input int unsigned dx,
                                             input int unsigned i);
        return x0 + i * dx;
    endfunction

    // width of an unsigned square of a (cnt_w+1)-bit signed difference
    function automatic int unsigned prod_w(input int unsigned cnt_w);
        return 2 * (cnt_w + 1);
    endfunction

    // ring mode only when the ring is thinner than the disc
    function automatic bit ring_mode(input int unsigned r, input int unsigned ring_w);
        return (ring_w != 0) && (ring_w < r);
    endfunction

    function automatic longint unsigned r2_out(input int unsigned r);
        return longint'(r) * longint'(r);
    endfunction

    // inner threshold; unused (0) when the ring degenerates to a filled disc
    function automatic longint unsigned r2_in(input int unsigned r, input int unsigned ring_w);
        if (!ring_mode(r, ring_w)) begin
            return 64'd0;
        end
        return longint'(r - ring_w) * longint'(r - ring_w);
    endfunction

    localparam longint unsigned R2_OUT = r2_out(DEF_R);
    localparam longint unsigned R2_IN  = r2_in(DEF_R, DEF_RING_W);

endpackage

// File: rtl/circle_hit_pipe_if.sv
// Purpose: pixel-stream bundle between the VGA timing generator, the hit tester and the colour mux.
// master: drives pixel/frame/mask inputs, reads the delayed pixel and hit vector.
// slave : the hit tester.
interface circle_hit_pipe_if #(
    parameter int unsigned N_CIRC = 5,
    parameter int unsigned CNT_W  = 11
);
    logic              pix_valid_i;
    logic [CNT_W-1:0]  hcnt_i;
    logic [CNT_W-1:0]  vcnt_i;
    logic              frame_start_i;
    logic [N_CIRC-1:0] on_mask_i;
    logic [N_CIRC-1:0] blink_en_i;
    logic              pix_valid_o;
    logic [CNT_W-1:0]  hcnt_o;
    logic [CNT_W-1:0]  vcnt_o;
    logic [N_CIRC-1:0] hit_o;

    modport master (
        output pix_valid_i, hcnt_i, vcnt_i, frame_start_i, on_mask_i, blink_en_i,
        input  pix_valid_o, hcnt_o, vcnt_o, hit_o
    );

    modport slave (
        input  pix_valid_i, hcnt_i, vcnt_i, frame_start_i, on_mask_i, blink_en_i,
        output pix_valid_o, hcnt_o, vcnt_o, hit_o
    );
endinterface

// File: rtl/circle_hit_lane.sv
// Purpose: per-circle dx path and radius compare (stages 1-3 for one circle).
// Ports: clk, rst_n; i_hcnt (raw pixel x); i_dy2_s2 (shared stage-2 dy^2);
//        o_in_c (combinational stage-3 inside flag, registered by the top).
module circle_hit_lane
    import circle_hit_pkg::*;
#(
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned XC     = 120,
    parameter int unsigned R      = 60,
    parameter int unsigned RING_W = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CNT_W-1:0]            i_hcnt,
    input  logic [prod_w(CNT_W)-1:0]    i_dy2_s2,
    output logic                        o_in_c
);
    localparam int unsigned SW = CNT_W + 1;
    localparam int unsigned PW = prod_w(CNT_W);
    localparam int unsigned DW = PW + 1;

    localparam logic [DW-1:0]        R2O  = DW'(r2_out(R));
    localparam logic [DW-1:0]        R2I  = DW'(r2_in(R, RING_W));
    localparam bit                   RING = ring_mode(R, RING_W);
    localparam logic signed [SW-1:0] XC_S = SW'(XC);

    logic signed [SW-1:0] w_h_s;
    logic signed [SW-1:0] r_dx;
    logic [SW-1:0]        w_mag;
    logic [PW-1:0]        r_dx2;
    logic [DW-1:0]        w_d2;

    assign w_h_s = $signed({1'b0, i_hcnt});
    // |dx| fits unsigned SW bits, so the square never exceeds PW bits
    assign w_mag = r_dx[SW-1] ? SW'(-r_dx) : SW'(r_dx);

    // stage 1: signed dx, stage 2: dx^2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dx  <= '0;
            r_dx2 <= '0;
        end else begin
            r_dx  <= w_h_s - XC_S;
            r_dx2 <= PW'(w_mag) * PW'(w_mag);
        end
    end

    // stage 3: full-width distance compare
    always_comb begin
        w_d2   = DW'(r_dx2) + DW'(i_dy2_s2);
        o_in_c = RING ? ((w_d2 <= R2O) && (w_d2 > R2I)) : (w_d2 <= R2O);
    end

endmodule

// File: rtl/circle_hit_pipe.sv
// Purpose: 3-cycle pipelined hit test of each pixel against N_CIRC evenly spaced circles,
//          with per-pixel masks and frame-synchronous blinking.
// Ports: clk, rst_n (async active-low); io_bus (slave): pixel, frame pulse and masks in,
//        delayed pixel and per-circle hit vector out.
module circle_hit_pipe
    import circle_hit_pkg::*;
#(
    parameter int unsigned N_CIRC       = 5,
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned X0           = 120,
    parameter int unsigned DX           = 140,
    parameter int unsigned Y0           = 80,
    parameter int unsigned R            = 60,
    parameter int unsigned RING_W       = 0,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    circle_hit_pipe_if.slave io_bus
);
    localparam int unsigned SW = CNT_W + 1;
    localparam int unsigned PW = prod_w(CNT_W);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic signed [SW-1:0] Y0_S    = SW'(Y0);
    localparam logic [BW-1:0]        CNT_TOP = BW'(BLINK_FRAMES - 1);

    // stage 1
    logic                 r_valid_s1;
    logic [CNT_W-1:0]     r_h_s1;
    logic [CNT_W-1:0]     r_v_s1;
    logic [N_CIRC-1:0]    r_mask_s1;
    logic [N_CIRC-1:0]    r_blink_s1;
    logic signed [SW-1:0] r_dy_s1;
    // stage 2
    logic                 r_valid_s2;
    logic [CNT_W-1:0]     r_h_s2;
    logic [CNT_W-1:0]     r_v_s2;
    logic [N_CIRC-1:0]    r_mask_s2;
    logic [N_CIRC-1:0]    r_blink_s2;
    logic [PW-1:0]        r_dy2_s2;
    // stage 3 / outputs
    logic                 r_valid_o;
    logic [CNT_W-1:0]     r_h_o;
    logic [CNT_W-1:0]     r_v_o;
    logic [N_CIRC-1:0]    r_hit;
    // blink state
    logic [BW-1:0]        r_blink_cnt;
    logic                 r_blink_phase;

    logic signed [SW-1:0] w_v_s;
    logic [SW-1:0]        w_dy_mag;
    logic [N_CIRC-1:0]    w_in;
    logic [N_CIRC-1:0]    w_hit_c;

    assign w_v_s    = $signed({1'b0, io_bus.vcnt_i});
    assign w_dy_mag = r_dy_s1[SW-1] ? SW'(-r_dy_s1) : SW'(r_dy_s1);

    // per-circle dx path and compare
    for (genvar gi = 0; gi < N_CIRC; gi++) begin : g_lane
        circle_hit_lane #(
            .CNT_W  (CNT_W),
            .XC     (centre_x(X0, DX, gi)),
            .R      (R),
            .RING_W (RING_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_hcnt   (io_bus.hcnt_i),
            .i_dy2_s2 (r_dy2_s2),
            .o_in_c   (w_in[gi])
        );
    end

    // blinked circles are hidden while the phase is low; the phase used is the pre-toggle value
    assign w_hit_c = w_in & r_mask_s2 & (~r_blink_s2 | {N_CIRC{r_blink_phase}})
                   & {N_CIRC{r_valid_s2}};

    // pixel, mask and shared dy pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_s1 <= 1'b0;
            r_h_s1     <= '0;
            r_v_s1     <= '0;
            r_mask_s1  <= '0;
            r_blink_s1 <= '0;
            r_dy_s1    <= '0;
            r_valid_s2 <= 1'b0;
            r_h_s2     <= '0;
            r_v_s2     <= '0;
            r_mask_s2  <= '0;
            r_blink_s2 <= '0;
            r_dy2_s2   <= '0;
            r_valid_o  <= 1'b0;
            r_h_o      <= '0;
            r_v_o      <= '0;
            r_hit      <= '0;
        end else begin
            r_valid_s1 <= io_bus.pix_valid_i;
            r_h_s1     <= io_bus.hcnt_i;
            r_v_s1     <= io_bus.vcnt_i;
            r_mask_s1  <= io_bus.on_mask_i;
            r_blink_s1 <= io_bus.blink_en_i;
            r_dy_s1    <= w_v_s - Y0_S;
            r_valid_s2 <= r_valid_s1;
            r_h_s2     <= r_h_s1;
            r_v_s2     <= r_v_s1;
            r_mask_s2  <= r_mask_s1;
            r_blink_s2 <= r_blink_s1;
            r_dy2_s2   <= PW'(w_dy_mag) * PW'(w_dy_mag);
            r_valid_o  <= r_valid_s2;
            r_h_o      <= r_h_s2;
            r_v_o      <= r_v_s2;
            r_hit      <= w_hit_c;
        end
    end

    // frame counter; phase toggles every BLINK_FRAMES frame starts, starting visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (io_bus.frame_start_i) begin
            if (r_blink_cnt == CNT_TOP) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign io_bus.pix_valid_o = r_valid_o;
    assign io_bus.hcnt_o      = r_h_o;
    assign io_bus.vcnt_o      = r_v_o;
    assign io_bus.hit_o       = r_hit;

endmodule

// File: tb/tb_circle_hit_pipe.sv
// Purpose: self-checking bench for circle_hit_pipe; a filled-disc instance and a ring instance
//          share one stimulus stream and are compared against a geometric reference model.
module tb_circle_hit_pipe;
    localparam int N    = 5;
    localparam int CW   = 11;
    localparam int BF   = 2;
    localparam int RW   = 10;
    localparam int MAXC = 4096;

    typedef struct {
        bit           v;
        int           h;
        int           y;
        bit           fs;
        bit [N-1:0]   m;
        bit [N-1:0]   b;
        bit           flushed;
        int           fc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circle_hit_pipe_if #(.N_CIRC(N), .CNT_W(CW)) bf ();
    circle_hit_pipe_if #(.N_CIRC(N), .CNT_W(CW)) br ();

    circle_hit_pipe #(.N_CIRC(N), .CNT_W(CW), .BLINK_FRAMES(BF)) dut_f (
        .clk(clk), .rst_n(rst_n), .io_bus(bf.slave));
    circle_hit_pipe #(.N_CIRC(N), .CNT_W(CW), .RING_W(RW), .BLINK_FRAMES(BF)) dut_r (
        .clk(clk), .rst_n(rst_n), .io_bus(br.slave));

    rec_t recs [MAXC];
    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int rst_hold = 1;

    // geometric reference: squared distance to each centre versus the radius thresholds
    function automatic logic [N-1:0] model_hit(input int h, input int y, input bit [N-1:0] m,
                                               input bit [N-1:0] b, input bit ph, input int ringw);
        logic [N-1:0] res = '0;
        for (int i = 0; i < N; i++) begin
            int dx = h - (120 + 140 * i);
            int dy = y - 80;
            int d2 = dx * dx + dy * dy;
            bit in = (d2 <= 60 * 60);
            if (ringw > 0 && ringw < 60) in = in && (d2 > (60 - ringw) * (60 - ringw));
            res[i] = in && m[i] && (!b[i] || ph);
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // outputs seen now belong to the pixel driven three cycles earlier
    task automatic check_cycle();
        int c = n - 3;
        logic pv = 1'b0;
        logic [31:0] eh = 0, ev = 0;
        logic [N-1:0] hf = '0, hr = '0;
        if (c >= 0 && !recs[c].flushed) begin
            bit ph = ((recs[c+1].fc / BF) % 2) == 0;
            pv = recs[c].v;
            eh = recs[c].h;
            ev = recs[c].y;
            if (recs[c].v) begin
                hf = model_hit(recs[c].h, recs[c].y, recs[c].m, recs[c].b, ph, 0);
                hr = model_hit(recs[c].h, recs[c].y, recs[c].m, recs[c].b, ph, RW);
            end
        end
        chk($sformatf("fill_valid c%0d", c), 32'(bf.pix_valid_o), 32'(pv));
        chk($sformatf("fill_hcnt c%0d", c),  32'(bf.hcnt_o), eh);
        chk($sformatf("fill_vcnt c%0d", c),  32'(bf.vcnt_o), ev);
        chk($sformatf("fill_hit c%0d", c),   32'(bf.hit_o), 32'(hf));
        chk($sformatf("ring_valid c%0d", c), 32'(br.pix_valid_o), 32'(pv));
        chk($sformatf("ring_hit c%0d", c),   32'(br.hit_o), 32'(hr));
    endtask

    task automatic step(input bit v, input int h, input int y, input bit fs,
                        input bit [N-1:0] m, input bit [N-1:0] b);
        int prev;
        @(posedge clk);
        #1;
        check_cycle();
        if (rst_hold > 0) begin
            rst_hold--;
            rst_n = 1'b0;
        end else begin
            rst_n = 1'b1;
        end
        bf.pix_valid_i = v; bf.hcnt_i = CW'(h); bf.vcnt_i = CW'(y);
        bf.frame_start_i = fs; bf.on_mask_i = m; bf.blink_en_i = b;
        br.pix_valid_i = v; br.hcnt_i = CW'(h); br.vcnt_i = CW'(y);
        br.frame_start_i = fs; br.on_mask_i = m; br.blink_en_i = b;
        prev = (n == 0 || recs[n-1].flushed) ? 0 : recs[n-1].fc;
        recs[n].v = v; recs[n].h = h; recs[n].y = y; recs[n].fs = fs;
        recs[n].m = m; recs[n].b = b;
        recs[n].flushed = !rst_n;
        recs[n].fc = rst_n ? prev + int'(fs) : 0;
        n++;
    endtask

    task automatic px(input int h, input int y);
        step(1'b1, h, y, 1'b0, '1, '0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 0, 1'b0, '1, '0);
    endtask

    // asynchronous reset in the middle of a cycle; outputs must clear without a clock edge
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_fill_valid", 32'(bf.pix_valid_o), 32'd0);
        chk("async_fill_hit",   32'(bf.hit_o), 32'd0);
        chk("async_ring_valid", 32'(br.pix_valid_o), 32'd0);
        chk("async_ring_hit",   32'(br.hit_o), 32'd0);
        for (int i = 0; i < n; i++) recs[i].flushed = 1'b1;
        rst_hold = 1;
    endtask

    initial begin
        bf.pix_valid_i = 1'b0; bf.hcnt_i = '0; bf.vcnt_i = '0;
        bf.frame_start_i = 1'b0; bf.on_mask_i = '0; bf.blink_en_i = '0;
        br.pix_valid_i = 1'b0; br.hcnt_i = '0; br.vcnt_i = '0;
        br.frame_start_i = 1'b0; br.on_mask_i = '0; br.blink_en_i = '0;
        #2;
        chk("reset_fill_valid", 32'(bf.pix_valid_o), 32'd0);
        chk("reset_fill_hit",   32'(bf.hit_o), 32'd0);
        chk("reset_ring_hit",   32'(br.hit_o), 32'd0);
        idle(2);

        // centre, radius edges, ring edges, counter maxima
        px(120, 80); px(180, 80); px(181, 80); px(400, 140); px(400, 141);
        px(175, 80); px(170, 80); px(2047, 2047); px(0, 0); px(680, 20);
        idle(3);

        // masks and valid qualifier, mask flipped between back-to-back pixels
        step(1'b1, 400, 80, 1'b0, 5'b11011, '0);
        step(1'b0, 260, 80, 1'b0, '1, '0);
        step(1'b1, 400, 80, 1'b0, '1, '0);
        step(1'b1, 400, 80, 1'b0, 5'b11011, '0);
        step(1'b1, 400, 80, 1'b0, '1, '0);
        idle(3);

        // blink across six frames; circle 0 always drawn
        for (int f = 0; f < 6; f++) begin
            step(1'b1, 400, 80, 1'b0, '1, 5'b00100);
            step(1'b1, 120, 80, 1'b0, '1, 5'b00100);
            step(1'b0, 0, 0, 1'b1, '1, '0);
            idle(2);
        end

        // frame start arriving while the pixel sits in the last stage
        step(1'b1, 400, 80, 1'b0, '1, 5'b00100);
        idle(1);
        step(1'b0, 0, 0, 1'b1, '1, '0);
        step(1'b1, 400, 80, 1'b0, '1, 5'b00100);
        step(1'b0, 0, 0, 1'b1, '1, '0);
        idle(3);

        // reset during a streak of hits
        for (int i = 0; i < 5; i++) px(120, 80);
        mid_reset();
        step(1'b1, 120, 80, 1'b0, '1, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 400, 80, 1'b0, '1, 5'b00100);
        idle(3);

        // randomized pixels clustered around the circles plus full-range corners
        for (int k = 0; k < 1200; k++) begin
            bit v = ($urandom_range(0, 3) != 0);
            int ci = $urandom_range(0, N - 1);
            int h = 120 + 140 * ci + $urandom_range(0, 140) - 70;
            int y = 80 + $urandom_range(0, 140) - 70;
            if ($urandom_range(0, 9) == 0) begin
                h = $urandom_range(0, 2047);
                y = $urandom_range(0, 2047);
            end
            step(v, h, y, ($urandom_range(0, 15) == 0), N'($urandom), N'($urandom));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
